// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants, state encoding and helpers for the
//               four-way round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Arbiter state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Convert a requester index into its one-hot grant vector
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux4to1_beh_1.sv
`default_nettype none
// ============================================================================
// Module      : mux4to1_beh_1
// Description : Behavioural 4:1 single-bit multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4to1_beh_1 (
    input  logic [3:0] data_in,
    input  logic [1:0] ctrl_sel,
    output logic       data_out
);

    // Select one of four data bits
    always_comb begin
        data_out = 1'b0;
        case (ctrl_sel)
            2'd0:    data_out = data_in[0];
            2'd1:    data_out = data_in[1];
            2'd2:    data_out = data_in[2];
            default: data_out = data_in[3];
        endcase
    end

endmodule : mux4to1_beh_1
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational four-way request picker. Default build searches
//               round-robin starting after 'last'. With MUX_ARB_FIXED_PRIO_EN
//               defined the lowest index wins, and the excluded index is only
//               dropped when some other request is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    input  logic               exclude_en,
    input  logic [SEL_W-1:0]   exclude_idx,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] w_masked;

    // Remove the excluded requester from the candidate pool
    always_comb begin
        w_masked = exclude_en ? (req & ~onehot(exclude_idx)) : req;
    end

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic               w_unused_last;
    logic [NUM_REQ-1:0] w_pool;

    assign w_unused_last = ^last;

    // Lowest index wins; fall back to the excluded one if it is alone
    always_comb begin
        w_pool = (|w_masked) ? w_masked : req;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_pool[k]) begin
                found = 1'b1;
                idx   = SEL_W'(k);
            end
        end
    end
`else
    logic [SEL_W-1:0] w_cand;

    // Search last+1 .. last+4 (mod 4); first pending request wins
    always_comb begin
        found  = 1'b0;
        idx    = last;
        w_cand = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = last + SEL_W'(k);
            if (!found && w_masked[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end
`endif

endmodule : rr_pick4
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin scheduler sharing a 4:1 bit mux between four
//               requesters, with a valid/ready output and a per-tenure limit
//               of MAX_HOLD accepted transfers.
//               Optional macro: MUX_ARB_FIXED_PRIO_EN (fixed lowest-index
//               priority instead of round-robin).
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  data_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic                data_out,
    output logic [SEL_W-1:0]    ctrl_sel,
    output logic [NUM_REQ-1:0]  grant,
    output logic [HOLD_W-1:0]   xfer_cnt
);

    localparam logic [HOLD_W-1:0] c_last_cnt = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic [HOLD_W-1:0]  r_cnt;
    logic [SEL_W-1:0]   r_last;

    logic               w_busy;
    logic               w_xfer;
    logic               w_rel_a;
    logic               w_rel_b;
    logic               w_release;
    logic               w_excl_en;
    logic [SEL_W-1:0]   w_pick_last;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    assign w_busy    = (r_state == ST_BUSY);
    assign out_valid = w_busy & req[r_sel];
    assign w_xfer    = out_valid & out_ready;
    assign w_rel_a   = w_busy & ~req[r_sel];
    assign w_rel_b   = w_xfer & (r_cnt == c_last_cnt);
    assign w_release = w_rel_a | w_rel_b;

    // Picker context: in BUSY the grantee becomes the new pointer on release
    always_comb begin
        w_pick_last = w_busy ? r_sel : r_last;
`ifdef MUX_ARB_FIXED_PRIO_EN
        w_excl_en   = w_release;
`else
        w_excl_en   = w_rel_a;
`endif
    end

    rr_pick4 u_pick (
        .req         (req),
        .last        (w_pick_last),
        .exclude_en  (w_excl_en),
        .exclude_idx (r_sel),
        .found       (w_found),
        .idx         (w_idx)
    );

    mux4to1_beh_1 u_mux (
        .data_in  (data_in),
        .ctrl_sel (r_sel),
        .data_out (data_out)
    );

    // Grant state machine, tenure counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_last  <= 2'b11;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= onehot(w_idx);
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                        r_last <= r_sel;
`endif
                        r_cnt  <= '0;
                        if (w_found) begin
                            r_grant <= onehot(w_idx);
                            r_sel   <= w_idx;
                        end else begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign ctrl_sel = r_sel;
    assign xfer_cnt = r_cnt;

endmodule : mux4_rr_arbiter
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Directed self-checking bench for mux4_rr_arbiter (default
//               round-robin build, MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] data_in;
    logic       out_ready;
    logic       out_valid;
    logic       data_out;
    logic [1:0] ctrl_sel;
    logic [3:0] grant;
    logic [3:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .ctrl_sel  (ctrl_sel),
        .grant     (grant),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset(input logic [3:0] r, input logic rdy, input logic [3:0] d);
        rst = 1'b1; req = r; out_ready = rdy; data_in = d;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; out_ready = 1'b0; data_in = 4'b1010;
        @(negedge clk); @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (ctrl_sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", ctrl_sel); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", xfer_cnt); end
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data got %b exp 0", data_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", grant); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL first_cnt got %0d exp 0", xfer_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b exp 1", out_valid); end
    endtask

    // Continues from test_reset: grant=0001, cnt=0, out_ready now raised.
    task automatic test_rotation;
        logic [3:0] exp_g;
        logic       exp_d;
        out_ready = 1'b1; data_in = 4'b1010;
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 4; k++) begin
                exp_g = 4'b0001 << (t % 4);
                exp_d = ((t % 4) == 1) || ((t % 4) == 3);
                checks++; if (grant !== exp_g) begin errors++; $display("FAIL rot_grant t%0d k%0d got %b exp %b", t, k, grant, exp_g); end
                checks++; if (xfer_cnt !== 4'(k)) begin errors++; $display("FAIL rot_cnt t%0d got %0d exp %0d", t, xfer_cnt, k); end
                checks++; if (data_out !== exp_d) begin errors++; $display("FAIL rot_data t%0d got %b exp %b", t, data_out, exp_d); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rot_valid t%0d got %b exp 1", t, out_valid); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_early_release;
        apply_reset(4'b0101, 1'b1, 4'b0100);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL early_g0 got %b exp 0001", grant); end
        @(negedge clk); @(negedge clk);
        checks++; if (xfer_cnt !== 4'd2) begin errors++; $display("FAIL early_cnt got %0d exp 2", xfer_cnt); end
        req = 4'b0100;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL early_grant got %b exp 0100", grant); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL early_cnt2 got %0d exp 0", xfer_cnt); end
        checks++; if (ctrl_sel !== 2'd2) begin errors++; $display("FAIL early_sel got %0d exp 2", ctrl_sel); end
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL early_data got %b exp 1", data_out); end
    endtask

    task automatic test_stall;
        apply_reset(4'b0010, 1'b0, 4'b0010);
        for (int c = 0; c < 5; c++) begin
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL stall_grant c%0d got %b exp 0010", c, grant); end
            checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt c%0d got %0d exp 0", c, xfer_cnt); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %b exp 1", c, out_valid); end
            checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL stall_data c%0d got %b exp 1", c, data_out); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (xfer_cnt !== 4'd1) begin errors++; $display("FAIL stall_resume got %0d exp 1", xfer_cnt); end
    endtask

    task automatic test_sole_timeout;
        logic [3:0] exp_c [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        apply_reset(4'b1000, 1'b1, 4'b1000);
        for (int c = 0; c < 5; c++) begin
            checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL sole_grant c%0d got %b exp 1000", c, grant); end
            checks++; if (xfer_cnt !== exp_c[c]) begin errors++; $display("FAIL sole_cnt c%0d got %0d exp %0d", c, xfer_cnt, exp_c[c]); end
            checks++; if (ctrl_sel !== 2'd3) begin errors++; $display("FAIL sole_sel c%0d got %0d exp 3", c, ctrl_sel); end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset;
        apply_reset(4'b0100, 1'b1, 4'b0000);
        @(negedge clk); @(negedge clk);
        checks++; if (xfer_cnt !== 4'd2) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 2", xfer_cnt); end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL mid_pre_grant got %b exp 0100", grant); end
        #2; rst = 1'b1; req = 4'b1111;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant got %b exp 0000", grant); end
        checks++; if (xfer_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", xfer_cnt); end
        checks++; if (ctrl_sel !== 2'd0) begin errors++; $display("FAIL mid_sel got %0d exp 0", ctrl_sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", grant); end
    endtask

    task automatic test_first_of_pair;
        apply_reset(4'b0110, 1'b0, 4'b0000);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pair_grant got %b exp 0010", grant); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got %b exp 0000", grant); end
        checks++; if (ctrl_sel !== 2'd1) begin errors++; $display("FAIL idle_sel_hold got %0d exp 1", ctrl_sel); end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_early_release();
        test_stall();
        test_sole_timeout();
        test_mid_reset();
        test_first_of_pair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux4_rr_arbiter
`default_nettype wire
